// File: rtl/spi_ram_pkg.sv
// Shared opcodes, error-bit indices, read FSM encoding and command layout
// for the SPI RAM controller.
package spi_ram_pkg;

   localparam int unsigned CMD_W  = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned WORD_W = CMD_W + DATA_W;
   localparam int unsigned ERR_W  = 3;

   localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
   localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

   localparam int unsigned ERR_NO_WADDR = 0;
   localparam int unsigned ERR_RD       = 1;
   localparam int unsigned ERR_RANGE    = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_OUT  = 2'd2
   } rd_state_e;

   typedef struct packed {
      logic [CMD_W-1:0]  op;
      logic [DATA_W-1:0] payload;
   } cmd_t;

endpackage

// File: rtl/sp_ram_array.sv
// Single-port byte RAM: synchronous write, registered synchronous read.
// Only the read-data register is reset; the storage itself is not.
module sp_ram_array
   import spi_ram_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder behind the SPI slave: address pointers with auto-increment,
// fixed-latency reads into tx_data, and sticky protocol-error flags.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned ADDR_SIZE  = 8,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] din,
   input  logic              rx_valid,
   input  logic              err_clr,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic [ERR_W-1:0]  err
);

   cmd_t                  cmd_c;
   logic                  in_range_c;
   logic                  wr_accept_c;
   logic                  rd_accept_c;
   logic [ERR_W-1:0]      err_set_c;
   logic [ADDR_SIZE-1:0]  ram_addr_c;

   rd_state_e             state;
   logic [ADDR_SIZE-1:0]  wr_ptr;
   logic [ADDR_SIZE-1:0]  rd_ptr;
   logic                  wr_vld;
   logic                  rd_vld;
   logic [DATA_W-1:0]     dout_q;
   logic [DATA_W-1:0]     ram_rdata;

   function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
      return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
   endfunction

   assign cmd_c      = cmd_t'(din);
   assign in_range_c = (9'(cmd_c.payload) < 9'(MEM_DEPTH));

   // Command decode and error-set conditions
   always_comb begin
      wr_accept_c = 1'b0;
      rd_accept_c = 1'b0;
      err_set_c   = '0;
      if (rx_valid) begin
         unique case (cmd_c.op)
            CMD_WR_ADDR: err_set_c[ERR_RANGE] = !in_range_c;
            CMD_WR_DATA: begin
               wr_accept_c            = wr_vld;
               err_set_c[ERR_NO_WADDR] = !wr_vld;
            end
            CMD_RD_ADDR: err_set_c[ERR_RANGE] = !in_range_c;
            CMD_RD_DATA: begin
               rd_accept_c       = rd_vld && (state == ST_IDLE);
               err_set_c[ERR_RD] = !(rd_vld && (state == ST_IDLE));
            end
            default: ;
         endcase
      end
   end

   // Data is captured from the RAM on acceptance, so a later write cannot corrupt it
   assign ram_addr_c = rd_accept_c ? rd_ptr : wr_ptr;

   sp_ram_array #(
      .DEPTH (MEM_DEPTH),
      .AW    (ADDR_SIZE)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_accept_c),
      .re    (rd_accept_c),
      .addr  (ram_addr_c),
      .wdata (cmd_c.payload),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tx_valid <= 1'b0;
         dout_q   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_vld   <= 1'b0;
         rd_vld   <= 1'b0;
         err      <= '0;
      end else begin
         tx_valid <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (rd_accept_c) begin
                  if (RD_LATENCY == 2) begin
                     state <= ST_RD_WAIT;
                  end else begin
                     state    <= ST_RD_OUT;
                     tx_valid <= 1'b1;
                  end
               end
            end
            ST_RD_WAIT: begin
               state    <= ST_RD_OUT;
               tx_valid <= 1'b1;
               dout_q   <= ram_rdata;
            end
            ST_RD_OUT: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase

         if (rx_valid && (cmd_c.op == CMD_WR_ADDR) && in_range_c) begin
            wr_ptr <= cmd_c.payload[ADDR_SIZE-1:0];
            wr_vld <= 1'b1;
         end else if (wr_accept_c) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end

         if (rx_valid && (cmd_c.op == CMD_RD_ADDR) && in_range_c) begin
            rd_ptr <= cmd_c.payload[ADDR_SIZE-1:0];
            rd_vld <= 1'b1;
         end else if (rd_accept_c) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end

         // Set beats clear on the same bit
         err <= (err_clr ? '0 : err) | err_set_c;
      end
   end

   // Single-edge latency returns the RAM read register directly
   assign dout = (RD_LATENCY == 1) ? ram_rdata : dout_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench: a vector table on a 256-deep/latency-1 instance and
// hand-written sequences on a 128-deep/latency-2 instance.
module tb_spi_ram_ctrl;

   typedef struct {
      logic [9:0] din;
      logic       rx;
      logic       clr;
      logic       exp_tx;
      logic [7:0] exp_dout;
      logic [2:0] exp_err;
   } vec_t;

   localparam int unsigned NVEC = 25;

   logic       clk;
   logic       a_rst_n, a_rx, a_clr, a_tx;
   logic [9:0] a_din;
   logic [7:0] a_dout;
   logic [2:0] a_err;
   logic       b_rst_n, b_rx, b_clr, b_tx;
   logic [9:0] b_din;
   logic [7:0] b_dout;
   logic [2:0] b_err;

   int checks;
   int failures;
   vec_t vecs [NVEC];

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(1)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .din(a_din), .rx_valid(a_rx), .err_clr(a_clr),
      .dout(a_dout), .tx_valid(a_tx), .err(a_err)
   );

   spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(7), .RD_LATENCY(2)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .din(b_din), .rx_valid(b_rx), .err_clr(b_clr),
      .dout(b_dout), .tx_valid(b_tx), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [9:0] d, input logic v, input logic c,
                               input logic t, input logic [7:0] o, input logic [2:0] e);
      vec_t r;
      r.din = d; r.rx = v; r.clr = c; r.exp_tx = t; r.exp_dout = o; r.exp_err = e;
      return r;
   endfunction

   task automatic chk(input string nm, input logic tx, input logic [7:0] d, input logic [2:0] e,
                      input logic etx, input logic [7:0] ed, input logic [2:0] ee);
      checks++;
      if (tx !== etx) begin
         failures++;
         $display("FAIL %s tx_valid: got %b expected %b", nm, tx, etx);
      end
      checks++;
      if (d !== ed) begin
         failures++;
         $display("FAIL %s dout: got %h expected %h", nm, d, ed);
      end
      checks++;
      if (e !== ee) begin
         failures++;
         $display("FAIL %s err: got %b expected %b", nm, e, ee);
      end
   endtask

   task automatic step_b(input string nm, input logic [9:0] d, input logic v, input logic c,
                         input logic etx, input logic [7:0] ed, input logic [2:0] ee);
      b_din = d; b_rx = v; b_clr = c;
      @(posedge clk); #1;
      b_rx = 1'b0; b_clr = 1'b0;
      chk(nm, b_tx, b_dout, b_err, etx, ed, ee);
   endtask

   initial begin
      checks = 0; failures = 0;
      a_rst_n = 1'b0; a_rx = 1'b0; a_clr = 1'b0; a_din = '0;
      b_rst_n = 1'b0; b_rx = 1'b0; b_clr = 1'b0; b_din = '0;

      vecs[0]  = mk(10'h1A5, 1, 0, 0, 8'h00, 3'b001);
      vecs[1]  = mk(10'h000, 0, 1, 0, 8'h00, 3'b000);
      vecs[2]  = mk(10'h010, 1, 0, 0, 8'h00, 3'b000);
      vecs[3]  = mk(10'h1AB, 1, 0, 0, 8'h00, 3'b000);
      vecs[4]  = mk(10'h1CD, 1, 0, 0, 8'h00, 3'b000);
      vecs[5]  = mk(10'h210, 1, 0, 0, 8'h00, 3'b000);
      vecs[6]  = mk(10'h300, 1, 0, 1, 8'hAB, 3'b000);
      vecs[7]  = mk(10'h000, 0, 0, 0, 8'hAB, 3'b000);
      vecs[8]  = mk(10'h300, 1, 0, 1, 8'hCD, 3'b000);
      vecs[9]  = mk(10'h000, 0, 0, 0, 8'hCD, 3'b000);
      vecs[10] = mk(10'h0FF, 1, 0, 0, 8'hCD, 3'b000);
      vecs[11] = mk(10'h111, 1, 0, 0, 8'hCD, 3'b000);
      vecs[12] = mk(10'h122, 1, 0, 0, 8'hCD, 3'b000);
      vecs[13] = mk(10'h2FF, 1, 0, 0, 8'hCD, 3'b000);
      vecs[14] = mk(10'h300, 1, 0, 1, 8'h11, 3'b000);
      vecs[15] = mk(10'h000, 0, 0, 0, 8'h11, 3'b000);
      vecs[16] = mk(10'h300, 1, 0, 1, 8'h22, 3'b000);
      vecs[17] = mk(10'h000, 0, 0, 0, 8'h22, 3'b000);
      vecs[18] = mk(10'h210, 1, 0, 0, 8'h22, 3'b000);
      vecs[19] = mk(10'h300, 1, 0, 1, 8'hAB, 3'b000);
      vecs[20] = mk(10'h300, 1, 0, 0, 8'hAB, 3'b010);
      vecs[21] = mk(10'h300, 1, 0, 1, 8'hCD, 3'b010);
      vecs[22] = mk(10'h300, 1, 1, 0, 8'hCD, 3'b010);
      vecs[23] = mk(10'h000, 0, 1, 0, 8'hCD, 3'b000);
      vecs[24] = mk(10'h300, 0, 0, 0, 8'hCD, 3'b000);

      repeat (2) @(posedge clk);
      #1;
      chk("a_reset", a_tx, a_dout, a_err, 1'b0, 8'h00, 3'b000);
      chk("b_reset", b_tx, b_dout, b_err, 1'b0, 8'h00, 3'b000);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;

      for (int i = 0; i < int'(NVEC); i++) begin
         a_din = vecs[i].din; a_rx = vecs[i].rx; a_clr = vecs[i].clr;
         @(posedge clk); #1;
         a_rx = 1'b0; a_clr = 1'b0;
         chk($sformatf("a_vec%0d", i), a_tx, a_dout, a_err,
             vecs[i].exp_tx, vecs[i].exp_dout, vecs[i].exp_err);
      end

      // Out-of-range addresses on the 128-deep instance
      step_b("b_waddr_oor",  10'h080, 1, 0, 0, 8'h00, 3'b100);
      step_b("b_wdata_noad", 10'h155, 1, 0, 0, 8'h00, 3'b101);
      step_b("b_clr1",       10'h000, 0, 1, 0, 8'h00, 3'b000);
      step_b("b_waddr_7f",   10'h07F, 1, 0, 0, 8'h00, 3'b000);
      step_b("b_wd33",       10'h133, 1, 0, 0, 8'h00, 3'b000);
      step_b("b_wd44_wrap",  10'h144, 1, 0, 0, 8'h00, 3'b000);
      step_b("b_waddr_oor2", 10'h080, 1, 0, 0, 8'h00, 3'b100);
      step_b("b_wd77",       10'h177, 1, 0, 0, 8'h00, 3'b100);
      step_b("b_raddr_7f",   10'h27F, 1, 0, 0, 8'h00, 3'b100);
      step_b("b_clr2",       10'h000, 0, 1, 0, 8'h00, 3'b000);

      // Latency 2 with a rejected back-to-back read
      step_b("b_rd1_acc",    10'h300, 1, 0, 0, 8'h00, 3'b000);
      step_b("b_rd1_out",    10'h300, 1, 0, 1, 8'h33, 3'b010);
      step_b("b_rd1_done",   10'h000, 0, 0, 0, 8'h33, 3'b010);
      step_b("b_rd2_acc",    10'h300, 1, 0, 0, 8'h33, 3'b010);
      step_b("b_rd2_out",    10'h000, 0, 0, 1, 8'h44, 3'b010);
      step_b("b_rd2_done",   10'h000, 0, 0, 0, 8'h44, 3'b010);
      step_b("b_rd3_acc",    10'h300, 1, 0, 0, 8'h44, 3'b010);
      step_b("b_rd3_out",    10'h000, 0, 0, 1, 8'h77, 3'b010);
      step_b("b_clr3",       10'h000, 0, 1, 0, 8'h77, 3'b000);

      // Write to the same address while a read is pending
      step_b("b_cf_waddr",   10'h07F, 1, 0, 0, 8'h77, 3'b000);
      step_b("b_cf_raddr",   10'h27F, 1, 0, 0, 8'h77, 3'b000);
      step_b("b_cf_rd",      10'h300, 1, 0, 0, 8'h77, 3'b000);
      step_b("b_cf_wr",      10'h199, 1, 0, 1, 8'h33, 3'b000);
      step_b("b_cf_idle",    10'h000, 0, 0, 0, 8'h33, 3'b000);
      step_b("b_cf_raddr2",  10'h27F, 1, 0, 0, 8'h33, 3'b000);
      step_b("b_cf_rd2",     10'h300, 1, 0, 0, 8'h33, 3'b000);
      step_b("b_cf_out2",    10'h000, 0, 0, 1, 8'h99, 3'b000);

      // Reset while a read is pending
      step_b("b_rs_raddr",   10'h27F, 1, 0, 0, 8'h99, 3'b000);
      step_b("b_rs_oor",     10'h280, 1, 0, 0, 8'h99, 3'b100);
      step_b("b_rs_rd",      10'h300, 1, 0, 0, 8'h99, 3'b100);
      b_rst_n = 1'b0;
      step_b("b_rs_reset",   10'h000, 0, 0, 0, 8'h00, 3'b000);
      b_rst_n = 1'b1;
      step_b("b_rs_idle1",   10'h000, 0, 0, 0, 8'h00, 3'b000);
      step_b("b_rs_idle2",   10'h000, 0, 0, 0, 8'h00, 3'b000);
      step_b("b_rs_rd_noad", 10'h300, 1, 0, 0, 8'h00, 3'b010);
      step_b("b_rs_idle3",   10'h000, 0, 0, 0, 8'h00, 3'b010);
      step_b("b_rs_idle4",   10'h000, 0, 0, 0, 8'h00, 3'b010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Downstream stage of the SPI slave. Consumes its 10-bit rx_data/rx_valid command words.
- Decodes the 2-bit opcode and keeps separate write and read address pointers.
- Stores bytes in a single-port synchronous RAM and returns read bytes on dout/tx_valid, which the SPI slave serialises onto MISO.
- Adds pointer auto-increment, a fixed read latency and sticky protocol-error flags.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; legal range 2..256.
- ADDR_SIZE, 8, pointer width; must equal clog2(MEM_DEPTH).
- RD_LATENCY, 1, clock edges from the accepted read-data command to tx_valid; legal values 1 or 2.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- din  input  10  command word: din[9:8] opcode, din[7:0] payload; sourced from SPI slave rx_data.
- rx_valid  input  1  din qualifier; one-cycle pulse per word.
- err_clr  input  1  clears all err bits.
- dout  output  8  read data; sink is SPI slave tx_data.
- tx_valid  output  1  one-cycle pulse; dout is valid in the same cycle.
- err  output  3  sticky flags: [0] wdata with no address, [1] rdata with no address or read busy, [2] address out of range.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - dout=0, tx_valid=0, err=0.
  - wr_ptr=0, rd_ptr=0, wr_vld=0, rd_vld=0; FSM goes to IDLE; any pending read is cancelled with no tx_valid.
  - RAM contents are not reset.
- Command words are acted on only when rx_valid=1. din is ignored otherwise.
- Opcode 00 (WR_ADDR):
  - payload < MEM_DEPTH: wr_ptr<=payload, wr_vld<=1.
  - payload >= MEM_DEPTH: set err[2]; wr_ptr and wr_vld are unchanged.
- Opcode 01 (WR_DATA):
  - wr_vld=1: mem[wr_ptr]<=payload, then wr_ptr<=wr_ptr+1, wrapping MEM_DEPTH-1 -> 0.
  - wr_vld=0: set err[0]; no write.
- Opcode 10 (RD_ADDR): same rules as WR_ADDR, applied to rd_ptr/rd_vld.
- Opcode 11 (RD_DATA):
  - Accepted when rd_vld=1 and the FSM is in IDLE. The payload is don't-care.
  - Reads mem[rd_ptr], then rd_ptr<=rd_ptr+1 with the same wrap rule.
  - Not accepted (rd_vld=0 or FSM not IDLE): set err[1]; the read is dropped.
- Read FSM states are IDLE, RD_WAIT and RD_OUT.
  - IDLE -> RD_WAIT on an accepted RD_DATA when RD_LATENCY=2.
  - IDLE -> RD_OUT on an accepted RD_DATA when RD_LATENCY=1.
  - RD_WAIT -> RD_OUT unconditionally.
  - RD_OUT asserts tx_valid=1 for exactly one cycle with dout=read data, then returns to IDLE.
- Timing: RD_DATA sampled at edge N gives tx_valid high during the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY edges after acceptance.
- dout holds its last value after tx_valid drops.
- Port conflict: a WR_DATA arriving while a read is pending is still performed. The pending read already captured its data, so returned data is never corrupted.
- err bits are sticky. Each bit is set on its condition. err_clr=1 clears all bits; if a set condition occurs in the same cycle, set wins for that bit.
- Only one opcode is processed per cycle; no internal queuing.

Decomposition:
- Package spi_ram_pkg holds:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - err bit indices ERR_NO_WADDR=0, ERR_RD=1, ERR_RANGE=2;
  - read FSM state encoding.
- Sub-module sp_ram_array holds the storage only: MEM_DEPTH x 8, synchronous write, registered synchronous read, ports we/re/addr/wdata/rdata.
- spi_ram_ctrl keeps the decode, pointers, FSM, latency stage and error logic.

Test Plan:
- Reset, then WR_DATA 0x1A5 with no address -> err=3'b001, no RAM write; err_clr pulse -> err=0.
- WR_ADDR 0x010, WR_DATA 0x1AB, WR_DATA 0x1CD; RD_ADDR 0x210; RD_DATA 0x300 twice -> two tx_valid pulses, dout=0xAB then 0xCD, each exactly RD_LATENCY edges after its command.
- WR_ADDR 0x0FF, WR_DATA 0x111, WR_DATA 0x122 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap). RD_ADDR 0x2FF, two RD_DATA -> dout 0x11 then 0x22.
- MEM_DEPTH=128: WR_ADDR 0x080 -> err[2]=1, wr_ptr unchanged. A following WR_DATA writes to the previous pointer, or sets err[0] if no earlier address.
- RD_LATENCY=2: RD_DATA, then a second RD_DATA on the next cycle -> err[1]=1 and a single tx_valid pulse for the first read only.
- Accepted RD_DATA, then rst_n=0 on the next edge -> tx_valid never asserts, err=0, and RD_DATA without a new RD_ADDR sets err[1].
